// File: rtl/alu_result_display_if.sv
// Bus between the ALU-result source and the BCD display stage.
// The source drives y/load; the display stage drives status, BCD and the 7-segment pins.
interface alu_result_display_if;
   logic [7:0]  y;
   logic        load;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output y,
      output load,
      input  busy,
      input  done,
      input  bcd,
      input  an,
      input  seg,
      input  dp
   );

   modport slave (
      input  y,
      input  load,
      output busy,
      output done,
      output bcd,
      output an,
      output seg,
      output dp
   );
endinterface

// File: rtl/alu_result_display.sv
// Converts an 8-bit result to BCD (double-dabble, 8 shift cycles; done 9 edges after load) and
// scans it onto a 3-digit active-low 7-segment display. A load outside IDLE is ignored; there is no stall.
module alu_result_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_result_display_if.slave  bus
);

   localparam int SCAN_W = $clog2(REFRESH_DIV);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_bin;
   logic [7:0]    w_bin_nxt;
   logic [11:0]   r_scr;
   logic [11:0]   w_scr_nxt;
   logic [2:0]    r_cnt;
   logic [2:0]    w_cnt_nxt;
   logic [11:0]   r_bcd;
   logic [11:0]   w_bcd_nxt;
   logic          r_busy;
   logic          w_busy_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic [11:0]   w_adj;
   logic [19:0]   w_shifted;

   logic [SCAN_W-1:0] r_scan_cnt;
   logic              w_wrap;
   logic [1:0]        r_idx;
   logic [1:0]        w_idx_nxt;
   logic [3:0]        r_an;
   logic [3:0]        w_an_nxt;
   logic [6:0]        r_seg;
   logic [6:0]        w_seg_nxt;
   logic [3:0]        w_digit;
   logic              w_blank;

   function automatic logic [3:0] dd_fix(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: adjust every nibble, then shift {scratch,bin} left.
   always_comb begin
      w_adj     = {dd_fix(r_scr[11:8]), dd_fix(r_scr[7:4]), dd_fix(r_scr[3:0])};
      w_shifted = {w_adj, r_bin} << 1;

      w_state_nxt = r_state;
      w_bin_nxt   = r_bin;
      w_scr_nxt   = r_scr;
      w_cnt_nxt   = r_cnt;
      w_bcd_nxt   = r_bcd;

      case (r_state)
         S_IDLE: begin
            if (bus.load) begin
               w_state_nxt = S_SHIFT;
               w_bin_nxt   = bus.y;
               w_scr_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         end
         S_SHIFT: begin
            w_scr_nxt = w_shifted[19:8];
            w_bin_nxt = w_shifted[7:0];
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               w_bcd_nxt   = w_shifted[19:8];
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_SHIFT);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // an/seg are computed from the upcoming index so they change on the same edge as it.
   always_comb begin
      w_wrap    = (r_scan_cnt == SCAN_LAST);
      w_idx_nxt = r_idx;
      if (w_wrap) begin
         w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end

      case (w_idx_nxt)
         2'd1: begin
            w_an_nxt = 4'b1101;
            w_digit  = r_bcd[7:4];
            w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
         end
         2'd2: begin
            w_an_nxt = 4'b1011;
            w_digit  = r_bcd[11:8];
            w_blank  = (r_bcd[11:8] == 4'd0);
         end
         default: begin
            w_an_nxt = 4'b1110;
            w_digit  = r_bcd[3:0];
            w_blank  = 1'b0;
         end
      endcase

      w_seg_nxt = w_blank ? 7'b1111111 : seg7(w_digit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_bin      <= '0;
         r_scr      <= '0;
         r_cnt      <= '0;
         r_bcd      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_scan_cnt <= '0;
         r_idx      <= 2'd0;
         r_an       <= 4'b1110;
         r_seg      <= 7'b1000000;
      end else begin
         r_state    <= w_state_nxt;
         r_bin      <= w_bin_nxt;
         r_scr      <= w_scr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bcd      <= w_bcd_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
         r_idx      <= w_idx_nxt;
         r_an       <= w_an_nxt;
         r_seg      <= w_seg_nxt;
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;
   assign bus.an   = r_an;
   assign bus.seg  = r_seg;
   assign bus.dp   = 1'b1;

endmodule
